// File: rtl/piso_serial_tx_pkg.sv
// rtl/piso_serial_tx_pkg.sv - shared types and defaults for the PISO serial transmitter
package piso_serial_tx_pkg;

    localparam int PISO_WIDTH_DEFAULT = 32;
    localparam int PISO_CNT_W_DEFAULT = 6;

    // Transmitter control state: waiting for a word, or streaming it out.
    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_t;

    // Operation applied to the shift register on the next rising edge.
    typedef enum logic [1:0] {
        SR_HOLD  = 2'd0,
        SR_LOAD  = 2'd1,
        SR_SHIFT = 2'd2
    } sr_mode_t;

endpackage

// File: rtl/piso_serial_tx_if.sv
// rtl/piso_serial_tx_if.sv - load handshake and serial stream bundle
interface piso_serial_tx_if
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             frame_done;

    // Producer of words and consumer of serial bits.
    modport master (
        output load_valid,
        output data_in,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  frame_done
    );

    // The transmitter itself.
    modport slave (
        input  load_valid,
        input  data_in,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output frame_done
    );

endinterface

// File: rtl/piso_d_ff.sv
// rtl/piso_d_ff.sv - single D flip-flop cell with async active-low preset and reset
module piso_d_ff (
    input  logic C,
    input  logic D,
    input  logic nP,
    input  logic nR,
    output logic Q
);

    // Reset dominates preset; otherwise capture D on the rising edge.
    always_ff @(posedge C or negedge nR or negedge nP) begin
        if (!nR) begin
            Q <= 1'b0;
        end else if (!nP) begin
            Q <= 1'b1;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - loadable right-shift register with hold, built from D_FF cells
module piso_shift_reg
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             C,
    input  logic             nR,
    input  sr_mode_t         mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d;

    // Per-bit next value: parallel load, shift toward bit 0 with zero fill, or hold.
    always_comb begin
        d = q;
        case (mode)
            SR_LOAD:  d = data_in;
            SR_SHIFT: d = {1'b0, q[WIDTH-1:1]};
            default:  d = q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        piso_d_ff u_ff (
            .C  (C),
            .D  (d[i]),
            .nP (1'b1),
            .nR (nR),
            .Q  (q[i])
        );
    end

endmodule

// File: rtl/piso_serial_tx.sv
// rtl/piso_serial_tx.sv - parallel-in/serial-out transmitter, LSB first, with back-pressure
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT,
    parameter int CNT_W = PISO_CNT_W_DEFAULT
) (
    input logic                C,
    input logic                nR,
    piso_serial_tx_if.slave    bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    piso_state_t      state;
    piso_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    sr_mode_t         sr_mode;
    logic [WIDTH-1:0] shreg;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .C       (C),
        .nR      (nR),
        .mode    (sr_mode),
        .data_in (bus.data_in),
        .q       (shreg)
    );

    // State and bit-counter registers; reset aborts any frame in flight.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state <= PISO_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter and shift-register command. The final accepted bit
    // is also a shift: only bit 0 is left, so shifting clears the register.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_mode   = SR_HOLD;
        case (state)
            PISO_IDLE: begin
                if (bus.load_valid) begin
                    sr_mode   = SR_LOAD;
                    cnt_nxt   = '0;
                    state_nxt = PISO_SHIFT;
                end
            end
            PISO_SHIFT: begin
                if (bus.ser_ready) begin
                    sr_mode = SR_SHIFT;
                    if (cnt == LAST_BIT) begin
                        cnt_nxt   = '0;
                        state_nxt = PISO_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = PISO_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.load_ready = (state == PISO_IDLE);
    assign bus.ser_valid  = (state == PISO_SHIFT);
    assign bus.ser_out    = (state == PISO_SHIFT) && shreg[0];
    assign bus.frame_done = (state == PISO_SHIFT) && (cnt == LAST_BIT);

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb/tb_piso_serial_tx.sv - directed table-driven bench for piso_serial_tx at WIDTH=8
module tb_piso_serial_tx;

    localparam int W = 8;

    typedef struct {
        string      name;
        logic       lv;
        logic [7:0] din;
        logic       sr;
        logic [3:0] exp_o;   // {load_ready, ser_valid, ser_out, frame_done}
    } vec_t;

    logic C;
    logic nR;
    int   vec_count  = 0;
    int   miss_count = 0;
    vec_t tbl[$];

    piso_serial_tx_if #(.WIDTH(W)) bus ();

    piso_serial_tx #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .C   (C),
        .nR  (nR),
        .bus (bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] obs();
        return {bus.load_ready, bus.ser_valid, bus.ser_out, bus.frame_done};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vec_count++;
        if (act !== exp_v) begin
            miss_count++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic add(input string nm, input logic lv, input logic [7:0] din,
                       input logic sr, input logic [3:0] e);
        vec_t v;
        v.name  = nm;
        v.lv    = lv;
        v.din   = din;
        v.sr    = sr;
        v.exp_o = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic lv, input logic [7:0] din, input logic sr);
        bus.load_valid = lv;
        bus.data_in    = din;
        bus.ser_ready  = sr;
    endtask

    initial begin
        logic [7:0] w;
        int         rise;
        logic       seen_low;

        drive(1'b0, 8'h00, 1'b0);
        nR = 1'b0;

        // Test 1: reset state, then a reset asserted mid-frame acts before any edge
        #1;
        check("t1_reset_at_start", {28'd0, obs()}, 32'h8);
        #3 nR = 1'b1;
        step();
        drive(1'b1, 8'hFF, 1'b1);
        step();
        check("t1_first_bit", {28'd0, obs()}, 32'h6);
        drive(1'b0, 8'h00, 1'b1);
        step();
        step();
        check("t1_mid_frame", {28'd0, obs()}, 32'h6);
        #3 nR = 1'b0;
        #1;
        check("t1_async_reset", {28'd0, obs()}, 32'h8);
        #2 nR = 1'b1;
        step();
        check("t1_after_release", {28'd0, obs()}, 32'h8);

        // Test 2: 8'hA5, no stalls
        w = 8'hA5;
        add("t2_load", 1'b1, w, 1'b1, {2'b01, w[0], 1'b0});
        for (int k = 1; k < W; k++)
            add($sformatf("t2_bit%0d", k), 1'b0, 8'h00, 1'b1, {2'b01, w[k], k == W - 1});
        add("t2_idle", 1'b0, 8'h00, 1'b1, 4'b1000);

        // Test 3: 8'h81 with a 3-cycle stall on bit 2
        w = 8'h81;
        add("t3_load", 1'b1, w, 1'b1, {2'b01, w[0], 1'b0});
        add("t3_bit1", 1'b0, 8'h00, 1'b1, {2'b01, w[1], 1'b0});
        add("t3_bit2", 1'b0, 8'h00, 1'b1, {2'b01, w[2], 1'b0});
        for (int s = 0; s < 3; s++)
            add($sformatf("t3_stall%0d", s), 1'b0, 8'h00, 1'b0, {2'b01, w[2], 1'b0});
        for (int k = 3; k < W; k++)
            add($sformatf("t3_bit%0d", k), 1'b0, 8'h00, 1'b1, {2'b01, w[k], k == W - 1});
        add("t3_idle", 1'b0, 8'h00, 1'b1, 4'b1000);

        // Test 4: load during SHIFT ignored; frame_done held while last bit stalls
        add("t4_load", 1'b1, 8'h00, 1'b1, 4'b0100);
        add("t4_bit1_ign", 1'b1, 8'hFF, 1'b1, 4'b0100);
        add("t4_bit2_ign", 1'b1, 8'hFF, 1'b1, 4'b0100);
        for (int k = 3; k < W; k++)
            add($sformatf("t4_bit%0d", k), 1'b0, 8'h00, 1'b1, {3'b010, k == W - 1});
        add("t4_last_stall", 1'b0, 8'h00, 1'b0, 4'b0101);
        add("t4_idle", 1'b0, 8'h00, 1'b1, 4'b1000);

        foreach (tbl[i]) begin
            drive(tbl[i].lv, tbl[i].din, tbl[i].sr);
            step();
            check(tbl[i].name, {28'd0, obs()}, {28'd0, tbl[i].exp_o});
        end
        drive(1'b0, 8'h00, 1'b1);

        // Test 5: reset after bit 4 of 8'h3C, then a clean 8'hC3 frame
        w = 8'h3C;
        drive(1'b1, w, 1'b1);
        step();
        check("t5_bit0", {28'd0, obs()}, {28'd0, 2'b01, w[0], 1'b0});
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t5_bit%0d", k), {28'd0, obs()}, {28'd0, 2'b01, w[k], 1'b0});
        end
        #3 nR = 1'b0;
        #1;
        check("t5_async_reset", {28'd0, obs()}, 32'h8);
        #1 nR = 1'b1;
        step();
        check("t5_no_residue", {28'd0, obs()}, 32'h8);
        w = 8'hC3;
        drive(1'b1, w, 1'b1);
        step();
        check("t5_c3_bit0", {28'd0, obs()}, {28'd0, 2'b01, w[0], 1'b0});
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 1; k < W; k++) begin
            step();
            check($sformatf("t5_c3_bit%0d", k), {28'd0, obs()},
                  {28'd0, 2'b01, w[k], k == W - 1});
        end
        step();
        check("t5_c3_idle", {28'd0, obs()}, 32'h8);

        // Test 6: load_valid held high, second word starts 9 cycles after first load edge
        drive(1'b1, 8'h55, 1'b1);
        step();
        check("t6_w1_bit0", {28'd0, obs()}, 32'h6);
        bus.data_in = 8'h0F;
        rise     = -1;
        seen_low = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 8)
                check("t6_gap_idle", {28'd0, obs()}, 32'h8);
            if (!bus.ser_valid) begin
                seen_low = 1'b1;
            end else if (seen_low) begin
                rise = k;
                break;
            end
        end
        check("t6_restart_cycle", rise, 32'd9);
        w = 8'h0F;
        check("t6_w2_bit0", {28'd0, obs()}, {28'd0, 2'b01, w[0], 1'b0});
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 1; k < W; k++) begin
            step();
            check($sformatf("t6_w2_bit%0d", k), {28'd0, obs()},
                  {28'd0, 2'b01, w[k], k == W - 1});
        end
        step();
        check("t6_w2_idle", {28'd0, obs()}, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
